// File: rtl/axi_master_cmd.sv
// axi_master_cmd: single-outstanding AXI3 initiator. Each accepted command becomes
// one write burst (AW -> W beats -> B) or one read burst (AR -> R beats), then a
// one-cycle done pulse that reports the worst response seen. A per-handshake
// watchdog aborts a stalled transaction with SLVERR and done_timeout.
module axi_master_cmd #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic        aclk,
  input  logic        areset,
  // local command port
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [3:0]  cmd_id,
  input  logic [31:0] cmd_addr,
  input  logic [3:0]  cmd_len,
  // write beat stream in
  input  logic [31:0] wdat,
  input  logic [3:0]  wdat_strb,
  input  logic        wdat_valid,
  output logic        wdat_ready,
  // read beat stream out
  output logic [31:0] rd_data,
  output logic        rd_valid,
  output logic        rd_last,
  // completion
  output logic        done,
  output logic [1:0]  done_resp,
  output logic        done_timeout,
  // AXI write address
  output logic [3:0]  awid,
  output logic [31:0] awadr,
  output logic [3:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic [1:0]  awlock,
  output logic [3:0]  awcache,
  output logic [2:0]  awprot,
  output logic        awvalid,
  input  logic        awready,
  // AXI write data
  output logic [3:0]  wid,
  output logic [31:0] wrdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  // AXI write response
  input  logic [3:0]  bid,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready,
  // AXI read address
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [3:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  // AXI read data
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready
);

  typedef enum logic [2:0] {
    IDLE, WR_ADDR, WR_DATA, WR_RESP, RD_ADDR, RD_DATA, DONE
  } state_t;

  localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  state_t          state;
  logic [3:0]      id_q;
  logic [31:0]     addr_q;
  logic [3:0]      len_q;
  logic [3:0]      beat_cnt;
  logic [1:0]      worst;
  logic [WD_W-1:0] wd_cnt;

  logic aw_hs, w_hs, b_hs, ar_hs, r_hs, any_hs;
  logic wd_active, wd_expire, w_load;
  logic [3:0] load_idx;
  logic [1:0] b_worst, r_worst;

  // Fixed AXI attributes: 32-bit INCR bursts, normal non-cacheable unprivileged accesses.
  assign awsize  = 3'b010;
  assign arsize  = 3'b010;
  assign awburst = 2'b01;
  assign arburst = 2'b01;
  assign awlock  = 2'b00;
  assign arlock  = 2'b00;
  assign awcache = 4'b0000;
  assign arcache = 4'b0000;
  assign awprot  = 3'b000;
  assign arprot  = 3'b000;
  assign awid    = id_q;
  assign wid     = id_q;
  assign arid    = id_q;
  assign awadr   = addr_q;
  assign araddr  = addr_q;
  assign awlen   = len_q;
  assign arlen   = len_q;

  assign aw_hs  = awvalid & awready;
  assign w_hs   = wvalid  & wready;
  assign b_hs   = bvalid  & bready;
  assign ar_hs  = arvalid & arready;
  assign r_hs   = rvalid  & rready;
  assign any_hs = aw_hs | w_hs | b_hs | ar_hs | r_hs;

  assign wd_active = (state != IDLE) && (state != DONE);
  assign wd_expire = (TIMEOUT_CYCLES != 0) && wd_active && !any_hs && (wd_cnt == WD_LIMIT);

  // NOTE: wdat_ready is combinational so the W register refills in the same cycle its
  // current beat is taken; it never takes a beat once the last one is already loaded.
  assign wdat_ready = (state == WR_DATA) && !wd_expire && (!wvalid || (wready && !wlast));
  assign w_load     = wdat_valid & wdat_ready;
  // Index of the beat being loaded: the beat leaving this cycle has already been counted.
  assign load_idx   = w_hs ? beat_cnt + 4'd1 : beat_cnt;

  assign b_worst = (bresp > worst) ? bresp : worst;
  assign r_worst = (rresp > worst) ? rresp : worst;

  // Response ID and rlast are not needed: one transaction is outstanding and the burst
  // length is tracked locally; the low address bits are forced to zero on the bus.
  logic unused_inputs;
  assign unused_inputs = ^{bid, rid, rlast, cmd_addr[1:0]};

  // Command FSM with all bus and stream outputs registered.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      // NOTE: every output register, data included, is reset so the bus idles at zero.
      state        <= IDLE;
      cmd_ready    <= 1'b0;
      id_q         <= '0;
      addr_q       <= '0;
      len_q        <= '0;
      beat_cnt     <= '0;
      worst        <= '0;
      wd_cnt       <= '0;
      awvalid      <= 1'b0;
      wvalid       <= 1'b0;
      wlast        <= 1'b0;
      wrdata       <= '0;
      wstrb        <= '0;
      bready       <= 1'b0;
      arvalid      <= 1'b0;
      rready       <= 1'b0;
      rd_data      <= '0;
      rd_valid     <= 1'b0;
      rd_last      <= 1'b0;
      done         <= 1'b0;
      done_resp    <= '0;
      done_timeout <= 1'b0;
    end else begin
      done     <= 1'b0;
      rd_valid <= 1'b0;
      rd_last  <= 1'b0;

      if (!wd_active || any_hs) wd_cnt <= '0;
      else                      wd_cnt <= wd_cnt + 1'b1;

      if (wd_expire) begin
        awvalid      <= 1'b0;
        wvalid       <= 1'b0;
        wlast        <= 1'b0;
        bready       <= 1'b0;
        arvalid      <= 1'b0;
        rready       <= 1'b0;
        done         <= 1'b1;
        done_resp    <= 2'b10;
        done_timeout <= 1'b1;
        state        <= DONE;
      end else begin
        unique case (state)
          IDLE: begin
            cmd_ready <= 1'b1;
            if (cmd_valid && cmd_ready) begin
              cmd_ready    <= 1'b0;
              id_q         <= cmd_id;
              addr_q       <= {cmd_addr[31:2], 2'b00};
              len_q        <= cmd_len;
              beat_cnt     <= '0;
              worst        <= '0;
              done_timeout <= 1'b0;
              if (cmd_write) begin
                awvalid <= 1'b1;
                state   <= WR_ADDR;
              end else begin
                arvalid <= 1'b1;
                state   <= RD_ADDR;
              end
            end
          end
          WR_ADDR: begin
            if (aw_hs) begin
              awvalid <= 1'b0;
              state   <= WR_DATA;
            end
          end
          WR_DATA: begin
            // NOTE: a beat loaded in the same cycle the previous one leaves must keep
            // wvalid high; the later non-blocking assignment below wins.
            if (w_hs) begin
              wvalid <= 1'b0;
              if (wlast) begin
                wlast  <= 1'b0;
                bready <= 1'b1;
                state  <= WR_RESP;
              end else begin
                beat_cnt <= beat_cnt + 4'd1;
              end
            end
            if (w_load) begin
              wrdata <= wdat;
              wstrb  <= wdat_strb;
              wvalid <= 1'b1;
              wlast  <= (load_idx == len_q);
            end
          end
          WR_RESP: begin
            if (b_hs) begin
              worst        <= b_worst;
              bready       <= 1'b0;
              done         <= 1'b1;
              done_resp    <= b_worst;
              done_timeout <= 1'b0;
              state        <= DONE;
            end
          end
          RD_ADDR: begin
            if (ar_hs) begin
              arvalid <= 1'b0;
              rready  <= 1'b1;
              state   <= RD_DATA;
            end
          end
          RD_DATA: begin
            if (r_hs) begin
              rd_data  <= rdata;
              rd_valid <= 1'b1;
              worst    <= r_worst;
              if (beat_cnt == len_q) begin
                rd_last      <= 1'b1;
                rready       <= 1'b0;
                done         <= 1'b1;
                done_resp    <= r_worst;
                done_timeout <= 1'b0;
                state        <= DONE;
              end else begin
                beat_cnt <= beat_cnt + 4'd1;
              end
            end
          end
          DONE: begin
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
